// File: rtl/dmem_byte_arbiter_if.sv
// Word-request bus shared by the two requesters and the byte-wide data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_byte_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              busy;
  logic              gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, busy, gnt, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, busy, gnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_byte_arbiter.sv
// Round-robin arbiter sharing a byte-wide memory between two 32-bit word ports;
// each word moves as four big-endian byte beats, then a one-cycle ack.
module dmem_byte_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_byte_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              gnt_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       shadow0_q;
  logic [31:0]       shadow1_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;

  logic              arb_win;
  logic              beat_act;
  logic [7:0]        wbyte [4];
  logic              unused_addr_hi;

  // On a tie the port that did not win last time gets the grant.
  assign arb_win  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign beat_act = (state_q == BEAT);
  assign unused_addr_hi = ^{bus.addr0[31:ADDR_W], bus.addr1[31:ADDR_W]};

  // Lane 0 is the most significant byte, so the base address holds [31:24].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wbyte[gi] = wdata_q[31-8*gi -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= 32'h0;
      shadow0_q <= 32'h0;
      shadow1_q <= 32'h0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state_q <= BEAT;
            gnt_q   <= arb_win;
            last_q  <= arb_win;
            we_q    <= arb_win ? bus.we1 : bus.we0;
            base_q  <= arb_win ? bus.addr1[ADDR_W-1:0] : bus.addr0[ADDR_W-1:0];
            wdata_q <= arb_win ? bus.wdata1 : bus.wdata0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        BEAT: begin
          // ~cnt_q is the big-endian lane position (3 - k) of beat k.
          if (!we_q) begin
            if (gnt_q) shadow1_q[{~cnt_q, 3'b000} +: 8] <= bus.mem_rdata;
            else       shadow0_q[{~cnt_q, 3'b000} +: 8] <= bus.mem_rdata;
          end
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            if (gnt_q) ack1_q <= 1'b1;
            else       ack0_q <= 1'b1;
            // The last byte arrives on this same edge, so merge it directly.
            if (!we_q) begin
              if (gnt_q) rdata1_q <= {shadow1_q[31:8], bus.mem_rdata};
              else       rdata0_q <= {shadow0_q[31:8], bus.mem_rdata};
            end
          end
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = beat_act ? base_q + ADDR_W'(cnt_q) : '0;
  assign bus.mem_we    = beat_act & we_q;
  assign bus.mem_wdata = (beat_act && we_q) ? wbyte[cnt_q] : 8'h00;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = busy_q;
  assign bus.gnt       = gnt_q;
endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed bench for dmem_byte_arbiter: byte memory model, scoreboard of expected
// acks, and cycle-exact checks of beats, acks, wrap, reset abort and fairness.
module tb_dmem_byte_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_byte_arbiter_if #(.ADDR_W(8)) bus ();
  dmem_byte_arbiter #(.ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [7:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int ack_viol = 0;
  logic prev_ack = 1'b0;

  // At most one ack per cycle, never two ack cycles in a row.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack0 && bus.ack1) ack_viol++;
      if ((bus.ack0 || bus.ack1) && prev_ack) ack_viol++;
      prev_ack = bus.ack0 | bus.ack1;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic pop_check(input string tag, input int cyc);
    exp_t e;
    logic obs_port;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_ack"}, 32'(bus.ack0 | bus.ack1), 32'd0);
    end else begin
      e = sb.pop_front();
      obs_port = bus.ack1;
      $display("[TB] ack port %0d cycle %0d rdata0=%h rdata1=%h", obs_port, cyc,
               bus.rdata0, bus.rdata1);
      chk({tag, "_port"}, 32'(obs_port), 32'(e.port));
      chk({tag, "_cycle"}, cyc, e.cyc);
      if (e.rd) chk({tag, "_rdata"}, e.port ? bus.rdata1 : bus.rdata0, e.data);
    end
  endtask

  // One transfer from cycle 0 (request visible before the granting edge) to cycle 6.
  task automatic xfer(input string tag, input logic port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input bit hold, input bit move_addr);
    drive(port, we, addr, wdata);
    sb.push_back('{port: port, rd: ~we, data: exp_rd, cyc: 5});
    for (int c = 1; c <= 4; c++) begin
      step();
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(port));
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(we));
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), (addr + 32'(c - 1)) & 32'hFF);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), we ? 32'(byte_of(wdata, c - 1)) : 32'd0);
      chk({tag, "_no_early_ack"}, 32'(bus.ack0 | bus.ack1), 32'd0);
      if (move_addr && c == 2) bus.addr0 = 32'h0000_0080;
    end
    step();
    chk({tag, "_ack_own"}, 32'(port ? bus.ack1 : bus.ack0), 32'd1);
    chk({tag, "_ack_other"}, 32'(port ? bus.ack0 : bus.ack1), 32'd0);
    pop_check(tag, 5);
    if (!hold) begin
      if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    end
    step();
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ack_after"}, 32'(bus.ack0 | bus.ack1), 32'd0);
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      chk(tag, 32'(mem[8'(a + 8'(k))]), 32'(byte_of(w, k)));
  endtask

  initial begin
    int cyc;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;

    step(); step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_acks", 32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    rst_n = 1'b1;
    step();

    xfer("wr10", 1'b0, 1'b1, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    chk_mem("wr10_mem", 8'h10, 32'h1122_3344);

    xfer("rd10", 1'b1, 1'b0, 32'hFFFF_FF10, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    chk("rd10_rdata0_kept", bus.rdata0, 32'd0);

    xfer("wrFE", 1'b0, 1'b1, 32'hFE, 32'hA1B2_C3D4, 32'h0, 1'b0, 1'b0);
    chk_mem("wrFE_mem", 8'hFE, 32'hA1B2_C3D4);
    xfer("rdFE", 1'b0, 1'b0, 32'hFE, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0);

    xfer("wr40", 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    xfer("rd40a", 1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0);
    xfer("rd40b", 1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    step();
    chk("rd40_rdata0_hold", bus.rdata0, 32'hCAFE_F00D);

    xfer("wr20pre", 1'b1, 1'b1, 32'h20, 32'h0000_5566, 32'h0, 1'b0, 1'b0);

    // Abort a write of 0xDEADBEEF to 0x20 during beat 2.
    drive(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    step(); step(); step();
    chk("abort_beat2_addr", 32'(bus.mem_addr), 32'h22);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("abort_rdata0", bus.rdata0, 32'd0);
    #2;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ack0 || bus.ack1) cyc++;
    end
    chk("abort_no_ack", cyc, 0);
    chk_mem("abort_mem", 8'h20, 32'hDEAD_5566);

    xfer("mvaddr", 1'b0, 1'b1, 32'h30, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
    chk_mem("mvaddr_mem", 8'h30, 32'h0102_0304);

    // Tie from reset: both held, grants alternate starting with port 0.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    sb.push_back('{port: 1'b0, rd: 1'b1, data: 32'hCAFE_F00D, cyc: 5});
    sb.push_back('{port: 1'b1, rd: 1'b1, data: 32'h1122_3344, cyc: 11});
    sb.push_back('{port: 1'b0, rd: 1'b1, data: 32'hCAFE_F00D, cyc: 17});
    sb.push_back('{port: 1'b1, rd: 1'b1, data: 32'h1122_3344, cyc: 23});
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.ack0 || bus.ack1) begin
        pop_check("tie", c);
        if (sb.size() == 0) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    chk("tie_all_acked", sb.size(), 0);

    chk("ack_invariants", ack_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
